stream_qos_scheduler: RTL and testbench

// - Packet-level scheduler for STREAM_COUNT AXI-Stream-like inputs onto one output.
// - Picks the highest-QoS valid stream; round-robin tie-break; optional aging prevents starvation.
// - Grant is held until the last beat; output is registered; sits in front of the shared output link.

---
 rtl/stream_qos_scheduler.sv | 170 +++++++++++++++++
 tb/tb_stream_qos_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_qos_scheduler.sv
// Packet-level QoS scheduler: max-QoS winner, round-robin ties, grant held to the last beat.
// Starvation aging is built only when STREAM_QOS_SCHED_AGING_EN is defined.

`ifdef STREAM_QOS_SCHED_AGING_EN
module stream_qos_age_lane #(
    parameter int AGE_W     = 8,
    parameter int AGE_LIMIT = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [AGE_W-1:0] age_o
);
    logic [AGE_W-1:0] age_d, age_q;

    always_comb begin
        age_d = age_q;
        if (clr_i)
            age_d = '0;
        else if (inc_i && age_q != AGE_W'(AGE_LIMIT))
            age_d = age_q + AGE_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) age_q <= '0;
        else        age_q <= age_d;
    end

    assign age_o = age_q;
endmodule
`endif

module stream_qos_scheduler #(
    parameter  int T_DATA_WIDTH = 8,
    parameter  int T_QOS__WIDTH = 4,
    parameter  int STREAM_COUNT = 4,
    parameter  int AGE_LIMIT    = 7,
    localparam int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_i,
    input  logic [STREAM_COUNT-1:0]                   s_last_i,
    input  logic [STREAM_COUNT-1:0]                   s_valid_i,
    output logic [STREAM_COUNT-1:0]                   s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                   m_data_o,
    output logic [T_QOS__WIDTH-1:0]                   m_qos_o,
    output logic [T_ID___WIDTH-1:0]                   m_id_o,
    output logic                                     m_last_o,
    output logic                                     m_valid_o,
    input  logic                                     m_ready_i
);
    localparam int AGE_W = 8;

    typedef enum logic {IDLE, BUSY} state_e;
    typedef struct packed {
        logic [T_DATA_WIDTH-1:0] data;
        logic [T_QOS__WIDTH-1:0] qos;
        logic [T_ID___WIDTH-1:0] id;
        logic                    last;
    } beat_t;

    state_e                             state_d, state_q;
    logic [T_ID___WIDTH-1:0]            gnt_id_d, gnt_id_q, rr_ptr_d, rr_ptr_q, win_id;
    beat_t                              m_beat_d, m_beat_q;
    logic                               m_valid_d, m_valid_q;
    logic [STREAM_COUNT-1:0]            urgent, cand;
    logic [STREAM_COUNT-1:0][AGE_W-1:0] age;
    logic [T_QOS__WIDTH-1:0]            max_qos;
    logic [T_ID___WIDTH:0]              scan;
    logic                               found, accept, done;

`ifdef STREAM_QOS_SCHED_AGING_EN
    // A stream ages once per packet completion it was waiting through.
    for (genvar i = 0; i < STREAM_COUNT; i++) begin : g_age
        stream_qos_age_lane #(.AGE_W(AGE_W), .AGE_LIMIT(AGE_LIMIT)) u_age (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (done && gnt_id_q == T_ID___WIDTH'(i)),
            .inc_i (done && s_valid_i[i] && gnt_id_q != T_ID___WIDTH'(i)),
            .age_o (age[i])
        );
    end
`else
    assign age = '0;
`endif

    // With no counters age stays 0 and AGE_LIMIT >= 1, so nothing is ever urgent.
    for (genvar i = 0; i < STREAM_COUNT; i++) begin : g_urg
        assign urgent[i] = (age[i] == AGE_W'(AGE_LIMIT));
    end

    always_comb begin
        max_qos = '0;
        for (int i = 0; i < STREAM_COUNT; i++)
            if (s_valid_i[i] && s_qos_i[i] > max_qos) max_qos = s_qos_i[i];
        for (int i = 0; i < STREAM_COUNT; i++)
            cand[i] = (|(urgent & s_valid_i)) ? (urgent[i] & s_valid_i[i])
                                              : (s_valid_i[i] && s_qos_i[i] == max_qos);
        win_id = '0;
        found  = 1'b0;
        scan   = '0;
        for (int k = 0; k < STREAM_COUNT; k++) begin
            scan = {1'b0, rr_ptr_q} + (T_ID___WIDTH+1)'(k);
            if (scan >= (T_ID___WIDTH+1)'(STREAM_COUNT))
                scan = scan - (T_ID___WIDTH+1)'(STREAM_COUNT);
            if (!found && cand[scan[T_ID___WIDTH-1:0]]) begin
                found  = 1'b1;
                win_id = scan[T_ID___WIDTH-1:0];
            end
        end
    end

    always_comb begin
        s_ready_o = '0;
        if (state_q == BUSY) s_ready_o[gnt_id_q] = ~m_valid_q | m_ready_i;
    end

    assign accept = (state_q == BUSY) && s_valid_i[gnt_id_q] && s_ready_o[gnt_id_q];
    assign done   = accept && s_last_i[gnt_id_q];

    always_comb begin
        state_d   = state_q;
        gnt_id_d  = gnt_id_q;
        rr_ptr_d  = rr_ptr_q;
        m_beat_d  = m_beat_q;
        m_valid_d = m_valid_q & ~m_ready_i;
        case (state_q)
            IDLE: if (|s_valid_i) begin
                gnt_id_d = win_id;
                state_d  = BUSY;
            end
            BUSY: if (accept) begin
                m_beat_d  = '{data: s_data_i[gnt_id_q], qos: s_qos_i[gnt_id_q],
                              id: gnt_id_q, last: s_last_i[gnt_id_q]};
                m_valid_d = 1'b1;
                if (done) begin
                    state_d  = IDLE;
                    rr_ptr_d = (gnt_id_q == T_ID___WIDTH'(STREAM_COUNT-1)) ? '0
                                                                         : gnt_id_q + T_ID___WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_id_q  <= '0;
            rr_ptr_q  <= '0;
            m_beat_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_id_q  <= gnt_id_d;
            rr_ptr_q  <= rr_ptr_d;
            m_beat_q  <= m_beat_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_data_o  = m_beat_q.data;
    assign m_qos_o   = m_beat_q.qos;
    assign m_id_o    = m_beat_q.id;
    assign m_last_o  = m_beat_q.last;
    assign m_valid_o = m_valid_q;
endmodule

// File: tb/tb_stream_qos_scheduler.sv
// Scoreboard bench for stream_qos_scheduler: per-stream beat queues, packet-level reference
// model of the arbitration rules, and an output monitor that pops expected beats.
module tb_stream_qos_scheduler;
    localparam int N = 4, DW = 8, QW = 4, IW = 2, AL = 3;
`ifdef STREAM_QOS_SCHED_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0][DW-1:0] s_data_i = '0;
    logic [N-1:0][QW-1:0] s_qos_i = '0;
    logic [N-1:0] s_last_i = '0, s_valid_i = '0, s_ready_o;
    logic [DW-1:0] m_data_o;
    logic [QW-1:0] m_qos_o;
    logic [IW-1:0] m_id_o;
    logic m_last_o, m_valid_o;
    logic m_ready_i = 1'b1;

    stream_qos_scheduler #(.T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(N), .AGE_LIMIT(AL)) dut (
        .clk(clk), .rst_n(rst_n), .s_data_i(s_data_i), .s_qos_i(s_qos_i), .s_last_i(s_last_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .m_data_o(m_data_o), .m_qos_o(m_qos_o),
        .m_id_o(m_id_o), .m_last_o(m_last_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i));

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] d; logic [QW-1:0] q; logic l; int gap; } src_t;
    typedef struct packed { logic [DW-1:0] d; logic [QW-1:0] q; logic [IW-1:0] id; logic l; } exp_t;

    src_t srcq[N][$];
    int   gap_cnt[N];
    exp_t sb[$];
    int   out_ids[$];
    int   n_cmp = 0, n_bad = 0;
    logic [DW-1:0] data_ctr = '0;
    bit   mr_rand = 0;
    int   mr_hold = 0;
    // reference model state: packet owner, rotation start, 1-deep output slot, ages
    bit   mbusy = 0, mbuf = 0;
    logic [IW-1:0] mgnt = '0, mrr = '0;
    int   mage[N];

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    function automatic int id_at(input int k);
        return (k < out_ids.size()) ? out_ids[k] : -1;
    endfunction

    task automatic push_beat(input int s, input int q, input bit l, input int gap);
        src_t b;
        b.d = data_ctr; b.q = QW'(q); b.l = l; b.gap = gap;
        data_ctr = data_ctr + 8'd1;
        if (srcq[s].size() == 0) gap_cnt[s] = gap;
        srcq[s].push_back(b);
    endtask

    task automatic push_pkt(input int s, input int len, input int q, input bit rnd);
        for (int k = 0; k < len; k++)
            push_beat(s, rnd ? int'($urandom_range(0, 15)) : q, k == len - 1,
                      (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    endtask

    function automatic bit all_idle();
        bit e = (sb.size() == 0) && !mbusy && !mbuf;
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) e = 0;
        return e;
    endfunction

    // Winner: urgent streams first, else highest QoS; nearest to the rotation start wins ties.
    function automatic logic [IW-1:0] pick(input logic [N-1:0] v, input logic [N-1:0][QW-1:0] q);
        bit urg_any = 0;
        int mx = -1, best = 0, bestd = N, d;
        bit ok;
        for (int i = 0; i < N; i++) if (v[i] && mage[i] >= AL) urg_any = 1;
        for (int i = 0; i < N; i++) if (v[i] && int'(q[i]) > mx) mx = int'(q[i]);
        for (int i = 0; i < N; i++) begin
            ok = urg_any ? (v[i] && mage[i] >= AL) : (v[i] && int'(q[i]) == mx);
            d  = (i - int'(mrr) + N) % N;
            if (ok && d < bestd) begin best = i; bestd = d; end
        end
        return IW'(best);
    endfunction

    // stimulus driver: present queue fronts after each rising edge
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (gap_cnt[i] > 0) begin
                gap_cnt[i]--;
                s_valid_i[i] = 1'b0;
            end else s_valid_i[i] = (srcq[i].size() > 0);
            if (s_valid_i[i]) begin
                s_data_i[i] = srcq[i][0].d; s_qos_i[i] = srcq[i][0].q; s_last_i[i] = srcq[i][0].l;
            end else begin
                s_data_i[i] = DW'($urandom); s_qos_i[i] = QW'($urandom); s_last_i[i] = 1'($urandom);
            end
        end
        if (mr_hold > 0) begin m_ready_i = 1'b0; mr_hold--; end
        else m_ready_i = mr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // reference model + source pops, evaluated on the values the next edge will see
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        bit drain;
        if (!rst_n) begin
            mbusy = 0; mbuf = 0; mgnt = '0; mrr = '0;
            for (int i = 0; i < N; i++) mage[i] = 0;
        end else begin
            exp_rdy = '0;
            if (mbusy && (!mbuf || m_ready_i)) exp_rdy[mgnt] = 1'b1;
            n_cmp++;
            if (s_ready_o !== exp_rdy) begin
                n_bad++;
                $display("FAIL s_ready_o at %0t: got %b, want %b", $time, s_ready_o, exp_rdy);
            end
            for (int i = 0; i < N; i++)
                if (s_valid_i[i] && s_ready_o[i] && srcq[i].size() > 0) begin
                    void'(srcq[i].pop_front());
                    if (srcq[i].size() > 0) gap_cnt[i] = srcq[i][0].gap;
                end
            drain = mbuf && m_ready_i;
            if (!mbusy) begin
                if (drain) mbuf = 0;
                if (|s_valid_i) begin mgnt = pick(s_valid_i, s_qos_i); mbusy = 1; end
            end else if (s_valid_i[mgnt] && exp_rdy[mgnt]) begin
                sb.push_back('{d: s_data_i[mgnt], q: s_qos_i[mgnt], id: mgnt, l: s_last_i[mgnt]});
                mbuf = 1;
                if (s_last_i[mgnt]) begin
                    if (AGING)
                        for (int j = 0; j < N; j++)
                            if (j == int'(mgnt)) mage[j] = 0;
                            else if (s_valid_i[j] && mage[j] < AL) mage[j]++;
                    mrr = IW'((int'(mgnt) + 1) % N);
                    mbusy = 0;
                end
            end else if (drain) mbuf = 0;
        end
    end

    // output monitor: pop on every output handshake, hold check under backpressure
    always @(negedge clk) begin
        exp_t got, e, held;
        bit hold_v;
        got = '{d: m_data_o, q: m_qos_o, id: m_id_o, l: m_last_o};
        if (!rst_n) hold_v = 0;
        else begin
            if (hold_v) begin
                n_cmp++;
                if (!m_valid_o || got !== held) begin
                    n_bad++;
                    $display("FAIL hold at %0t: got v=%b %h, want v=1 %h", $time, m_valid_o, got, held);
                end
            end
            if (m_valid_o && m_ready_i) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL beat at %0t: got id=%0d d=%h, want no beat", $time, m_id_o, m_data_o);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        n_bad++;
                        $display("FAIL beat at %0t: got d=%h q=%h id=%0d l=%b, want d=%h q=%h id=%0d l=%b",
                                 $time, got.d, got.q, got.id, got.l, e.d, e.q, e.id, e.l);
                    end
                end
                out_ids.push_back(int'(m_id_o));
            end
            hold_v = m_valid_o && !m_ready_i;
            held = got;
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin srcq[i].delete(); gap_cnt[i] = 0; end
        sb.delete(); out_ids.delete(); mr_hold = 0; mr_rand = 0;
        #1;
        chk("reset m_valid_o", int'(m_valid_o), 0);
        chk("reset s_ready_o", int'(s_ready_o), 0);
        chk("reset m_id_o", int'(m_id_o), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string nm);
        int c = 0;
        while (!all_idle() && c < 20000) begin @(negedge clk); c++; end
        n_cmp++;
        if (!all_idle()) begin
            n_bad++;
            $display("FAIL drain %s: got busy after %0d cycles, want idle", nm, c);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        for (int i = 0; i < N; i++) gap_cnt[i] = 0;

        // higher QoS first, 2-cycle latency from valid to output
        do_reset();
        push_pkt(0, 1, 2, 0);
        push_pkt(2, 1, 9, 0);
        c = 0;
        @(posedge clk);
        while (c < 10) begin @(negedge clk); if (m_valid_o) break; c++; end
        chk("qos latency", c, 2);
        wait_drain("qos");
        chk("qos first id", id_at(0), 2);
        chk("qos second id", id_at(1), 0);

        // equal QoS rotates 0,1,2,3,0
        do_reset();
        for (int r = 0; r < 2; r++) for (int s = 0; s < N; s++) push_pkt(s, 1, 5, 0);
        wait_drain("rr");
        for (int k = 0; k < 5; k++) chk("rr order", id_at(k), k % N);

        // grant held across a valid gap while a higher-QoS stream waits
        do_reset();
        push_beat(1, 1, 0, 0); push_beat(1, 1, 0, 2); push_beat(1, 1, 1, 0);
        repeat (2) @(posedge clk);
        #2 push_pkt(3, 1, 15, 0);
        wait_drain("lock");
        for (int k = 0; k < 3; k++) chk("lock s1 beat", id_at(k), 1);
        chk("lock then s3", id_at(3), 3);

        // backpressure mid-packet
        do_reset();
        push_pkt(2, 4, 3, 0);
        c = 0;
        while (c < 20 && !m_valid_o) begin @(negedge clk); c++; end
        chk("bp first beat seen", int'(m_valid_o), 1);
        @(posedge clk); #2 mr_hold = 5;
        wait_drain("backpressure");
        chk("bp beat count", out_ids.size(), 4);

        // starvation: s0 qos=15 back-to-back, s1 qos=0 waiting
        do_reset();
        for (int p = 0; p < 6; p++) push_pkt(0, 1, 15, 0);
        push_pkt(1, 1, 0, 0);
        wait_drain("aging");
        c = -1;
        for (int k = 0; k < out_ids.size(); k++) if (c < 0 && out_ids[k] == 1) c = k;
        chk("aging s1 position", c, AGING ? AL : 6);

        // randomized traffic, reset mid-flight, then more randomized traffic
        do_reset();
        mr_rand = 1;
        for (int p = 0; p < 40; p++) push_pkt($urandom_range(0, N-1), $urandom_range(1, 4), 0, 1);
        repeat (60) @(posedge clk);
        do_reset();
        mr_rand = 1;
        for (int p = 0; p < 200; p++) push_pkt($urandom_range(0, N-1), $urandom_range(1, 4), 0, 1);
        wait_drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
